// File: rtl/risc_sequencer_pkg.sv
// risc_sequencer_pkg: shared state codes and instruction-field constants for the RISC core
package risc_sequencer_pkg;

   typedef enum logic [2:0] {
      RESET_STATE = 3'd0,
      FETCH_INSTR = 3'd1,
      READ_OPS    = 3'd2,
      EXECUTE     = 3'd3,
      WRITEBACK   = 3'd4,
      FETCH_WAIT  = 3'd5,
      HALTED      = 3'd6
   } State_Type;

   localparam int OPC_HI   = 31;
   localparam int OPC_LO   = 30;
   localparam int HALT_BIT = 26;

   function automatic logic is_halt_instr(input logic [31:0] instr);
      return (instr[OPC_HI:OPC_LO] == 2'b00) && instr[HALT_BIT];
   endfunction

endpackage

// File: rtl/risc_sequencer.sv
// risc_sequencer: instruction sequencer with PC, fetch handshake, halt/step and fetch timeout
module risc_sequencer
   import risc_sequencer_pkg::*;
#(
   parameter int PC_W          = 8,
   parameter int FETCH_TIMEOUT = 16,
   parameter int CNT_W         = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [31:0]      Crnt_Instrn,
   input  logic             PC_Load,
   input  logic [PC_W-1:0]  PC_Load_Val,
   input  logic             Instr_Ack,
   input  logic             Halt_Req,
   input  logic             Resume,
   input  logic             Step_Mode,
   output logic [2:0]       Current_State,
   output logic             Instr_Req,
   output logic [PC_W-1:0]  Instr_Addr,
   output logic             Halted,
   output logic             Fetch_Err,
   output logic [CNT_W-1:0] Instr_Count
);

   State_Type        state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ferr_q, ferr_d;
   logic             pend_q, pend_d;
   logic [7:0]       to_q, to_d;

   assign Current_State = state_q;
   assign Instr_Req     = state_q == FETCH_WAIT;
   assign Halted        = state_q == HALTED;
   assign Instr_Addr    = pc_q;
   assign Fetch_Err     = ferr_q;
   assign Instr_Count   = count_q;

   // next state, PC/count update, timeout counting and halt bookkeeping
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      ferr_d  = ferr_q;
      to_d    = to_q;
      pend_d  = pend_q | (Halt_Req && state_q != WRITEBACK && state_q != HALTED);
      case (state_q)
         RESET_STATE: begin
            state_d = FETCH_WAIT;
            to_d    = '0;
         end
         FETCH_WAIT: begin
            if (Instr_Ack) begin
               state_d = FETCH_INSTR;
            end else if (to_q == 8'(FETCH_TIMEOUT - 1)) begin
               state_d = HALTED;
               ferr_d  = 1'b1;
            end else begin
               to_d = to_q + 8'd1;
            end
         end
         FETCH_INSTR: state_d = READ_OPS;
         READ_OPS:    state_d = EXECUTE;
         EXECUTE:     state_d = WRITEBACK;
         WRITEBACK: begin
            pc_d    = PC_Load ? PC_Load_Val : pc_q + PC_W'(1);
            count_d = count_q + CNT_W'(1);
            state_d = (is_halt_instr(Crnt_Instrn) || pend_q || Halt_Req || Step_Mode) ? HALTED : FETCH_WAIT;
            to_d    = '0;
         end
         HALTED: begin
            if (Resume && !Halt_Req && !ferr_q) begin
               state_d = FETCH_WAIT;
               to_d    = '0;
            end
         end
         default: state_d = RESET_STATE;
      endcase
      if (state_d == HALTED) pend_d = 1'b0;
   end

   // state register; reset aborts any in-flight instruction
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= RESET_STATE;
         pc_q    <= '0;
         count_q <= '0;
         ferr_q  <= 1'b0;
         pend_q  <= 1'b0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         ferr_q  <= ferr_d;
         pend_q  <= pend_d;
         to_q    <= to_d;
      end
   end

endmodule
